// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between instruction fetch and
// load/store. Data port wins by default; a starvation counter forces a fetch grant periodically.
module mem_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              own;
  logic              we_q;
  logic [CNT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              starved;
  logic              grant_d;
  logic              grant_i;
  logic              capture;

  assign starved = (starve_cnt >= SC_W'(STARVE_LIMIT));
  assign capture = (state == WAIT) && (lat_cnt == '0);

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (d_req && (!starved || !if_req)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = (state == ISSUE);
    mem_we   = (state == ISSUE) && we_q;
    if_ready = (state == DONE) && (own == OWN_I);
    d_ready  = (state == DONE) && (own == OWN_D);
    if_stall = if_req && !if_ready;
    d_stall  = d_req && !d_ready;
  end

  // Access latch: the mem_* bus holds the last granted request between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own       <= OWN_I;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (grant_d) begin
      own       <= OWN_D;
      we_q      <= d_we;
      mem_addr  <= d_addr;
      mem_be    <= d_be;
      mem_wdata <= d_wdata;
    end else if (grant_i) begin
      own       <= OWN_I;
      we_q      <= 1'b0;
      mem_addr  <= if_addr;
      mem_be    <= 4'hF;
      mem_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else if (grant_i) begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= CNT_W'(MEM_LAT - 1);
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Stores leave both read registers untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (capture && !we_q) begin
      if (own == OWN_D) begin
        d_rdata <= mem_rdata;
      end else begin
        if_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the core's instruction-fetch port and its load/store port.
- Sits between the riscv core and the memory.
- Decides which requester is served, sequences each access (issue, wait, return), and generates per-port ready/stall signals for the pipeline hazard logic.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
MEM_LAT, 2, cycles from the mem_en cycle to the mem_rdata-valid cycle (legal range ≥1)
STARVE_LIMIT, 4, consecutive data grants with if_req pending before fetch is forced (legal range ≥1)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held high with if_addr stable until if_ready
if_addr  input  32  fetch address
if_rdata  output  32  fetched word, valid while if_ready=1
if_ready  output  1  one-cycle completion pulse for fetch
if_stall  output  1  combinational: if_req & ~if_ready
d_req  input  1  data request; held high with d_we/d_be/d_addr/d_wdata stable until d_ready
d_we  input  1  1=store, 0=load
d_be  input  4  byte enables for stores
d_addr  input  32  data address
d_wdata  input  32  store data
d_rdata  output  32  load data, valid while d_ready=1
d_ready  output  1  one-cycle completion pulse for data access (loads and stores)
d_stall  output  1  combinational: d_req & ~d_ready
mem_en  output  1  one-cycle access strobe
mem_we  output  1  write enable, qualified by mem_en
mem_be  output  4  byte enables; 4'b1111 for fetches
mem_addr  output  32  access address
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid exactly MEM_LAT cycles after the mem_en cycle

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Owner register `own` records the served port (I or D).
- IDLE:
  - No request: stay in IDLE.
  - Grant rule: if d_req and (starve_cnt < STARVE_LIMIT or !if_req), grant D. Otherwise, if if_req, grant I.
  - On a grant: latch the owner's address, we, be and wdata; go to ISSUE.
- ISSUE (one cycle):
  - mem_en=1; mem_* driven from the latched registers.
  - Counter loads MEM_LAT-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter is 0, mem_rdata is valid: capture it into the owner's rdata register and go to DONE.
- DONE (one cycle):
  - Owner's ready=1. The requester may drop or change its request at the end of this cycle.
  - No grant is made in DONE. Next state is IDLE.
- Latency: req sampled in IDLE at cycle T gives mem_en at T+1, rdata capture at T+1+MEM_LAT, and ready at T+2+MEM_LAT.
  - Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Stores: mem_we=1 in ISSUE. d_ready follows the same timing as a load. d_rdata holds its previous value.
- Starvation counter (3-bit minimum, saturating at STARVE_LIMIT):
  - Increments on each D grant made while if_req=1.
  - Clears on any I grant.
  - Clears on a D grant made while if_req=0.
- Outputs:
  - mem_en, mem_we and the ready pulses are 0 outside ISSUE and DONE respectively.
  - mem_addr, mem_be and mem_wdata hold their latched values otherwise.
  - if_rdata and d_rdata hold until they are overwritten.
- Simultaneous if_req and d_req in IDLE: the grant rule above applies; the loser stays pending with its stall signal asserted.
- A request that drops before its ready pulse is a protocol violation; the arbiter completes the access anyway.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE; starve_cnt, counter and own cleared.
  - mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, d_rdata=0, if_ready=0, d_ready=0.
  - An in-flight access is abandoned and no ready pulse is ever issued for it.
  - First grant possible in the first IDLE cycle after reset deasserts.

Test Plan:
- Single fetch (MEM_LAT=2): if_req=1, if_addr=0x0000_0010 at cycle 0; memory returns 0x0051_0093 → mem_en at cycle 1 with mem_addr=0x10, mem_be=4'hF; if_ready=1 and if_rdata=0x0051_0093 at cycle 4 only; if_stall=1 in cycles 0–3.
- Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF → one mem_en with mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF; d_ready at cycle 4; d_rdata unchanged.
- Contention: if_req and d_req both held high continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; each grant is 5 cycles apart.
- Priority with no starvation: d_req and if_req both rise at cycle 0 with starve_cnt=0 → D is served first (ready at 4); I is granted at cycle 5 and if_ready=1 at cycle 9.
- Reset mid-access: assert reset low during WAIT of a load → all outputs 0 immediately; after release with requests low, no ready pulse appears for 10 cycles; a new fetch then completes with standard 4-cycle latency.
- MEM_LAT=1 corner: single load → mem_en at cycle 1, capture at cycle 2, d_ready at cycle 3.
